// File: rtl/blink_pkg.sv
// Shared types and helpers for the multi-channel blink engine.
// Mode/state encodings and the even-channel mask used by ALTERNATE.
package blink_pkg;

   typedef enum logic [1:0] {
      SOLID     = 2'd0,
      BLINK     = 2'd1,
      BLINK_N   = 2'd2,
      ALTERNATE = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ON_PH  = 2'd1,
      OFF_PH = 2'd2,
      FINISH = 2'd3
   } state_t;

   localparam int MAX_CHANNELS = 64;

   // Bits 0,2,4,... set; callers slice down to their channel count.
   function automatic logic [MAX_CHANNELS-1:0] even_mask();
      logic [MAX_CHANNELS-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_CHANNELS; i += 2) begin
         m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/blink_sequencer_if.sv
// Control/status bundle between a blink_sequencer and its requester.
// master drives requests and configuration, slave (the engine) drives the LED outputs and status.
interface blink_sequencer_if #(
   parameter int CHANNELS = 4,
   parameter int CNT_W    = 8
);
   logic                start;
   logic                stop;
   logic [1:0]          mode;
   logic [CHANNELS-1:0] ch_mask;
   logic [CNT_W-1:0]    half_period;
   logic [CNT_W-1:0]    blink_count;
   logic [CHANNELS-1:0] out;
   logic                tick;
   logic                busy;
   logic                done;

   modport master (
      output start, stop, mode, ch_mask, half_period, blink_count,
      input  out, tick, busy, done
   );

   modport slave (
      input  start, stop, mode, ch_mask, half_period, blink_count,
      output out, tick, busy, done
   );
endinterface

// File: rtl/blink_sequencer_tick_gen.sv
// Free-running divide-by-DIV prescaler; tick is high while the count sits at DIV-1.
// clear restarts the count at 0 on the next edge so phase timing aligns to an accepted start.
module tick_gen #(
   parameter int DIV = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);
   localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   if (DIV < 2) begin : g_bad_div
      $error("tick_gen: DIV must be at least 2");
   end

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clear || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == LAST);
endmodule

// File: rtl/blink_sequencer.sv
// Multi-channel LED blink engine: SOLID, BLINK, counted BLINK_N and ALTERNATE modes.
// Outputs update one cycle after an accepted start; config is frozen while busy, stop aborts at once.
module blink_sequencer
   import blink_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int TICK_HZ     = 1,
   parameter int CHANNELS    = 4,
   parameter int CNT_W       = 8
) (
   input logic              clk,
   input logic              reset,
   blink_sequencer_if.slave bus
);
   localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
   localparam logic [MAX_CHANNELS-1:0] EVEN_ALL = even_mask();
   localparam logic [CHANNELS-1:0]     EVEN     = EVEN_ALL[CHANNELS-1:0];

   if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
      $error("blink_sequencer: CHANNELS out of range");
   end

   state_t              state_q, state_d;
   mode_t               mode_q, mode_d;
   logic [CHANNELS-1:0] mask_q, mask_d;
   logic [CNT_W-1:0]    hp_q, hp_d;
   logic [CNT_W-1:0]    lim_q, lim_d;
   logic [CNT_W-1:0]    phase_q, phase_d;
   logic [CNT_W-1:0]    blinks_q, blinks_d;
   logic [CHANNELS-1:0] out_q, out_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic                tick;
   logic                accept;
   mode_t               start_mode;
   logic [CNT_W-1:0]    eff_hp_in;
   logic                phase_end;
   logic                last_blink;
   logic [CHANNELS-1:0] on_pat;
   logic [CHANNELS-1:0] off_pat;
   logic [CHANNELS-1:0] start_pat;

   assign accept     = (state_q == IDLE) && bus.start && !bus.stop;
   assign start_mode = mode_t'(bus.mode);
   assign eff_hp_in  = (bus.half_period == '0) ? CNT_W'(1) : bus.half_period;
   assign phase_end  = tick && (phase_q == (hp_q - CNT_W'(1)));
   assign last_blink = ((blinks_q + CNT_W'(1)) == lim_q);
   assign on_pat     = (mode_q == ALTERNATE) ? (mask_q & EVEN) : mask_q;
   assign off_pat    = (mode_q == ALTERNATE) ? (mask_q & ~EVEN) : '0;
   assign start_pat  = (start_mode == ALTERNATE) ? (bus.ch_mask & EVEN) : bus.ch_mask;

   tick_gen #(.DIV(DIV)) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .clear (accept),
      .tick  (tick)
   );

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      mask_d   = mask_q;
      hp_d     = hp_q;
      lim_d    = lim_q;
      phase_d  = phase_q;
      blinks_d = blinks_q;
      out_d    = out_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               mode_d   = start_mode;
               mask_d   = bus.ch_mask;
               hp_d     = eff_hp_in;
               lim_d    = bus.blink_count;
               phase_d  = '0;
               blinks_d = '0;
               // A zero-length counted run completes without ever lighting anything.
               if (start_mode == BLINK_N && bus.blink_count == '0) begin
                  state_d = FINISH;
                  out_d   = '0;
               end else begin
                  state_d = ON_PH;
                  out_d   = start_pat;
               end
            end
         end
         ON_PH: begin
            if (mode_q != SOLID && tick) begin
               if (phase_end) begin
                  phase_d = '0;
                  state_d = OFF_PH;
                  out_d   = off_pat;
               end else begin
                  phase_d = phase_q + CNT_W'(1);
               end
            end
         end
         OFF_PH: begin
            if (tick) begin
               if (phase_end) begin
                  phase_d = '0;
                  if (mode_q == BLINK_N && last_blink) begin
                     blinks_d = blinks_q + CNT_W'(1);
                     state_d  = FINISH;
                     out_d    = '0;
                  end else begin
                     if (mode_q == BLINK_N) begin
                        blinks_d = blinks_q + CNT_W'(1);
                     end
                     state_d = ON_PH;
                     out_d   = on_pat;
                  end
               end else begin
                  phase_d = phase_q + CNT_W'(1);
               end
            end
         end
         FINISH: begin
            state_d  = IDLE;
            out_d    = '0;
            blinks_d = '0;
         end
         default: begin
            state_d = IDLE;
            out_d   = '0;
         end
      endcase

      // stop wins over everything, including a phase end landing in the same cycle.
      if (state_q != IDLE && bus.stop) begin
         state_d  = IDLE;
         out_d    = '0;
         phase_d  = '0;
         blinks_d = '0;
      end

      busy_d = (state_d != IDLE);
      done_d = (state_d == FINISH);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         mode_q   <= SOLID;
         mask_q   <= '0;
         hp_q     <= '0;
         lim_q    <= '0;
         phase_q  <= '0;
         blinks_q <= '0;
         out_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         mask_q   <= mask_d;
         hp_q     <= hp_d;
         lim_q    <= lim_d;
         phase_q  <= phase_d;
         blinks_q <= blinks_d;
         out_q    <= out_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.out  = out_q;
   assign bus.tick = tick;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
endmodule

// File: tb/tb_blink_sequencer.sv
// Randomized bench for blink_sequencer: a timeline model (elapsed cycles since start) predicts out/busy/done/tick.
module tb_blink_sequencer;
   localparam int DIV = 8;
   localparam logic [3:0] EVEN_T = 4'b0101;

   logic clk = 1'b0;
   logic reset = 1'b0;

   blink_sequencer_if #(.CHANNELS(4), .CNT_W(8)) bus_if ();

   blink_sequencer #(
      .CLK_FREQ_HZ (8),
      .TICK_HZ     (1),
      .CHANNELS    (4),
      .CNT_W       (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: a job is a timeline; m_e counts cycles since the accepting edge, m_pc cycles since the last prescaler clear.
   bit         m_active;
   bit         m_acc;
   int         m_e;
   int         m_end;
   int         m_per;
   int         m_pc;
   logic [1:0] m_mode;
   logic [3:0] m_mask;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_active = 1'b0;
         m_e      = 0;
         m_pc     = 0;
      end else begin
         m_acc = !m_active && bus_if.start && !bus_if.stop;
         if (m_active && bus_if.stop) begin
            m_active = 1'b0;
         end else if (m_acc) begin
            m_active = 1'b1;
            m_mode   = bus_if.mode;
            m_mask   = bus_if.ch_mask;
            m_per    = ((bus_if.half_period == 8'd0) ? 1 : int'(bus_if.half_period)) * DIV;
            m_end    = (bus_if.blink_count == 8'd0) ? 1 : 2 * int'(bus_if.blink_count) * m_per + 1;
            m_e      = 1;
         end else if (m_active) begin
            m_e++;
            if (m_mode == 2'd2 && m_e > m_end) m_active = 1'b0;
         end
         m_pc = m_acc ? 0 : m_pc + 1;
      end
   end

   function automatic logic [3:0] exp_out();
      int ph;
      if (!m_active) return 4'b0000;
      if (m_mode == 2'd2 && m_e == m_end) return 4'b0000;
      ph = (m_e - 1) / m_per;
      case (m_mode)
         2'd0:    return m_mask;
         2'd3:    return (ph % 2 == 0) ? (m_mask & EVEN_T) : (m_mask & ~EVEN_T);
         default: return (ph % 2 == 0) ? m_mask : 4'b0000;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      check("out",  32'(bus_if.out),  32'(exp_out()));
      check("busy", 32'(bus_if.busy), 32'(m_active));
      check("done", 32'(bus_if.done), 32'(m_active && m_mode == 2'd2 && m_e == m_end));
      check("tick", 32'(bus_if.tick), 32'((m_pc % DIV) == DIV - 1));
   endtask

   task automatic run_job(input logic [1:0] mode, input logic [3:0] mask, input logic [7:0] hp,
                          input logic [7:0] cnt, input int stop_at, input bit with_stop, input bit noise);
      bus_if.mode        = mode;
      bus_if.ch_mask     = mask;
      bus_if.half_period = hp;
      bus_if.blink_count = cnt;
      bus_if.start       = 1'b1;
      bus_if.stop        = with_stop;
      step();
      bus_if.start = 1'b0;
      bus_if.stop  = 1'b0;
      for (int c = 1; c <= 600 && m_active; c++) begin
         bus_if.stop = (c == stop_at);
         if (noise) begin
            bus_if.mode        = 2'($urandom);
            bus_if.ch_mask     = 4'($urandom);
            bus_if.half_period = 8'($urandom);
            bus_if.blink_count = 8'($urandom);
            bus_if.start       = ($urandom_range(0, 3) == 0);
         end
         step();
         bus_if.start = 1'b0;
         bus_if.stop  = 1'b0;
      end
      check("job_end_busy", 32'(bus_if.busy), 32'd0);
      if (m_active) begin
         bus_if.stop = 1'b1;
         step();
         bus_if.stop = 1'b0;
      end
   endtask

   task automatic idle_gap(input int n);
      for (int i = 0; i < n; i++) begin
         bus_if.ch_mask     = 4'($urandom);
         bus_if.half_period = 8'($urandom);
         step();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] r_mode;
      int         r_stop;
      bus_if.start       = 1'b0;
      bus_if.stop        = 1'b0;
      bus_if.mode        = 2'd0;
      bus_if.ch_mask     = 4'd0;
      bus_if.half_period = 8'd0;
      bus_if.blink_count = 8'd0;

      repeat (3) @(negedge clk);
      check("rst_out",  32'(bus_if.out),  32'd0);
      check("rst_busy", 32'(bus_if.busy), 32'd0);
      check("rst_done", 32'(bus_if.done), 32'd0);
      check("rst_tick", 32'(bus_if.tick), 32'd0);
      reset = 1'b1;
      idle_gap(13);

      // Reset dropped mid-job, between clock edges.
      bus_if.mode        = 2'd1;
      bus_if.ch_mask     = 4'b1111;
      bus_if.half_period = 8'd1;
      bus_if.start       = 1'b1;
      step();
      bus_if.start = 1'b0;
      repeat (5) step();
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("midrst_out",  32'(bus_if.out),  32'd0);
      check("midrst_busy", 32'(bus_if.busy), 32'd0);
      check("midrst_done", 32'(bus_if.done), 32'd0);
      check("midrst_tick", 32'(bus_if.tick), 32'd0);
      @(negedge clk) reset = 1'b1;
      idle_gap(20);

      run_job(2'd2, 4'b0101, 8'd2, 8'd3, -1, 1'b0, 1'b0);
      idle_gap(3);
      run_job(2'd3, 4'b1111, 8'd1, 8'd0, 40, 1'b0, 1'b0);
      idle_gap(4);
      run_job(2'd2, 4'b1111, 8'd0, 8'd0, -1, 1'b0, 1'b0);
      idle_gap(2);
      run_job(2'd2, 4'b1010, 8'd0, 8'd2, -1, 1'b0, 1'b0);
      idle_gap(5);
      run_job(2'd1, 4'b0110, 8'd1, 8'd0, -1, 1'b1, 1'b0);
      idle_gap(3);
      run_job(2'd1, 4'b0011, 8'd2, 8'd0, 70, 1'b0, 1'b1);
      idle_gap(2);
      run_job(2'd0, 4'b1000, 8'd3, 8'd5, 60, 1'b0, 1'b1);
      idle_gap(6);

      for (int j = 0; j < 30; j++) begin
         r_mode = 2'($urandom);
         if (r_mode == 2'd2 && $urandom_range(0, 1) == 1) r_stop = -1;
         else r_stop = $urandom_range(1, (r_mode == 2'd2) ? 150 : 100);
         run_job(r_mode, 4'($urandom), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                 r_stop, ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
         idle_gap($urandom_range(0, 10));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
